// File: rtl/led_pwm_blink_driver.sv
// LED pin driver behind the GPIO out_port: global PWM brightness, per-LED blink
// masking and optional inversion, with pattern/config changes applied only at frame boundaries.
module led_pwm_blink_driver #(
   parameter int unsigned PRESCALE_DIV = 50,
   parameter int unsigned BLINK_FRAMES = 64
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        chipselect,
   input  logic [1:0]  address,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   input  logic [7:0]  led_in,
   output logic [7:0]  led_out
);

   localparam int unsigned PRE_W = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
   localparam int unsigned BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE_DIV - 1);
   localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

   typedef enum logic [1:0] {
      REG_CTRL   = 2'd0,
      REG_BRIGHT = 2'd1,
      REG_MASK   = 2'd2,
      REG_STATUS = 2'd3
   } reg_addr_e;

   typedef struct packed {
      logic inv;
      logic en;
   } ctrl_t;

   ctrl_t            ctrl_q, ctrl_d;
   logic [7:0]       bright_q, bright_d;
   logic [7:0]       mask_q, mask_d;
   logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
   logic [7:0]       pwm_cnt_q, pwm_cnt_d;
   logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
   logic             blink_phase_q, blink_phase_d;
   logic [7:0]       pat_a_q, pat_a_d;
   logic [7:0]       bright_a_q, bright_a_d;
   logic [7:0]       mask_a_q, mask_a_d;
   logic [7:0]       led_out_q, led_out_d;

   logic             wr_en;
   logic             tick;
   logic             frame_end;
   logic             load_active;
   logic [7:0]       lit;
   logic             pwm_on;
   logic             unused_wdata;

   assign wr_en        = chipselect && !write_n;
   assign unused_wdata = ^writedata[31:8];

   // Counters only run while enabled, so tick/frame_end are quiet when disabled.
   assign tick        = ctrl_q.en && (pre_cnt_q == PRE_LAST);
   assign frame_end   = tick && (pwm_cnt_q == 8'hFF);
   assign load_active = frame_end || !ctrl_q.en;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      ctrl_d   = ctrl_q;
      bright_d = bright_q;
      mask_d   = mask_q;
      if (wr_en) begin
         case (reg_addr_e'(address))
            REG_CTRL:   ctrl_d   = ctrl_t'(writedata[1:0]);
            REG_BRIGHT: bright_d = writedata[7:0];
            REG_MASK:   mask_d   = writedata[7:0];
            default:    ;
         endcase
      end
   end

   always_comb begin
      pre_cnt_d     = pre_cnt_q;
      pwm_cnt_d     = pwm_cnt_q;
      blink_cnt_d   = blink_cnt_q;
      blink_phase_d = blink_phase_q;
      if (!ctrl_q.en) begin
         pre_cnt_d     = '0;
         pwm_cnt_d     = '0;
         blink_cnt_d   = '0;
         blink_phase_d = 1'b0;
      end else begin
         pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;
         if (tick) begin
            pwm_cnt_d = pwm_cnt_q + 8'd1;
         end
         if (frame_end) begin
            if (blink_cnt_q == BLK_LAST) begin
               blink_cnt_d   = '0;
               blink_phase_d = ~blink_phase_q;
            end else begin
               blink_cnt_d = blink_cnt_q + 1'b1;
            end
         end
      end
   end

   // Active copies see the shadow values as they stood before any same-edge write.
   always_comb begin
      pat_a_d    = pat_a_q;
      bright_a_d = bright_a_q;
      mask_a_d   = mask_a_q;
      if (load_active) begin
         pat_a_d    = led_in;
         bright_a_d = bright_q;
         mask_a_d   = mask_q;
      end
   end

   assign lit       = pat_a_q & ~(mask_a_q & {8{blink_phase_q}});
   assign pwm_on    = (pwm_cnt_q < bright_a_q);
   assign led_out_d = (lit & {8{pwm_on && ctrl_q.en}}) ^ {8{ctrl_q.inv}};

   // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ctrl_q        <= '0;
         bright_q      <= 8'hFF;
         mask_q        <= 8'h00;
         pre_cnt_q     <= '0;
         pwm_cnt_q     <= 8'h00;
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
         pat_a_q       <= 8'h00;
         bright_a_q    <= 8'hFF;
         mask_a_q      <= 8'h00;
         led_out_q     <= 8'h00;
      end else begin
         ctrl_q        <= ctrl_d;
         bright_q      <= bright_d;
         mask_q        <= mask_d;
         pre_cnt_q     <= pre_cnt_d;
         pwm_cnt_q     <= pwm_cnt_d;
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
         pat_a_q       <= pat_a_d;
         bright_a_q    <= bright_a_d;
         mask_a_q      <= mask_a_d;
         led_out_q     <= led_out_d;
      end
   end

   assign led_out = led_out_q;

   always_comb begin
      readdata = '0;
      case (reg_addr_e'(address))
         REG_CTRL:   readdata[1:0] = ctrl_q;
         REG_BRIGHT: readdata[7:0] = bright_q;
         REG_MASK:   readdata[7:0] = mask_q;
         REG_STATUS: begin
            readdata[15:8] = pwm_cnt_q;
            readdata[0]    = blink_phase_q;
         end
         default:    ;
      endcase
   end

endmodule
